// File: rtl/fll_lead_detect_pipe.sv
// Pipelined leading-one detector for the FLL discriminator path, one search segment per stage,
// with a peak-position tracker. Define FLL_PENC_SIGNED_EN for two's-complement inputs.
module fll_lead_detect_pipe #(
   parameter int IN_WIDTH  = 18,
   parameter int MIN_POS   = 8,
   parameter int SEG_WIDTH = 5,
   parameter int OUT_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [IN_WIDTH-1:0]  in,
   input  logic                 max_clear,
   output logic                 out_valid,
   output logic [OUT_WIDTH-1:0] out_pos,
   output logic                 out_found,
   output logic                 out_neg,
   output logic [OUT_WIDTH-1:0] max_pos
);

   localparam int NSEG = (IN_WIDTH - MIN_POS + SEG_WIDTH - 1) / SEG_WIDTH;
   localparam logic [OUT_WIDTH-1:0] FLOOR_POS = OUT_WIDTH'(MIN_POS - 1);

   if (MIN_POS < 1 || IN_WIDTH <= MIN_POS || (2 ** OUT_WIDTH) <= IN_WIDTH - 1) begin : g_param_error
      $error("fll_lead_detect_pipe: illegal parameter combination");
   end

   // Valid semantics: in_valid marks one sample per cycle, always accepted (no ready);
   // out_valid pulses exactly NSEG cycles later; no valid means a bubble, not a stall.
   logic                 in_sign;
   logic [IN_WIDTH-1:0]  in_word;

`ifdef FLL_PENC_SIGNED_EN
   assign in_sign = in[IN_WIDTH-1];
`else
   assign in_sign = 1'b0;
`endif
   // Flipping by the sign turns "first bit differing from sign" into "first one" and clears the sign bit.
   assign in_word = in ^ {IN_WIDTH{in_sign}};

   logic                 st_v     [NSEG];
   logic                 st_found [NSEG];
   logic [OUT_WIDTH-1:0] st_pos   [NSEG];
   logic [IN_WIDTH-1:0]  st_data  [NSEG];
   logic                 st_neg   [NSEG];

   logic                 src_v     [NSEG];
   logic                 src_found [NSEG];
   logic [OUT_WIDTH-1:0] src_pos   [NSEG];
   logic [IN_WIDTH-1:0]  src_data  [NSEG];
   logic                 src_neg   [NSEG];

   logic                 nx_found [NSEG];
   logic [OUT_WIDTH-1:0] nx_pos   [NSEG];

   always_comb begin
      src_v[0]     = in_valid;
      src_found[0] = 1'b0;
      src_pos[0]   = FLOOR_POS;
      src_data[0]  = in_word;
      src_neg[0]   = in_sign;
      for (int k = 1; k < NSEG; k++) begin
         src_v[k]     = st_v[k-1];
         src_found[k] = st_found[k-1];
         src_pos[k]   = st_pos[k-1];
         src_data[k]  = st_data[k-1];
         src_neg[k]   = st_neg[k-1];
      end
   end

   // Stage k owns bits (IN_WIDTH-1-k*SEG_WIDTH) down to max of the segment bottom and MIN_POS;
   // ascending scan so the highest set bit wins.
   always_comb begin
      for (int k = 0; k < NSEG; k++) begin
         nx_found[k] = src_found[k];
         nx_pos[k]   = src_pos[k];
         if (!src_found[k]) begin
            for (int i = MIN_POS; i < IN_WIDTH; i++) begin
               if (i <= IN_WIDTH - 1 - k * SEG_WIDTH && i > IN_WIDTH - 1 - (k + 1) * SEG_WIDTH
                   && src_data[k][i]) begin
                  nx_found[k] = 1'b1;
                  nx_pos[k]   = OUT_WIDTH'(i);
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NSEG; k++) begin
            st_v[k]     <= 1'b0;
            st_found[k] <= 1'b0;
            st_pos[k]   <= FLOOR_POS;
            st_data[k]  <= '0;
            st_neg[k]   <= 1'b0;
         end
         max_pos <= FLOOR_POS;
      end else begin
         for (int k = 0; k < NSEG; k++) begin
            st_v[k]    <= src_v[k];
            st_data[k] <= src_data[k];
         end
         for (int k = 0; k < NSEG - 1; k++) begin
            st_found[k] <= nx_found[k];
            st_pos[k]   <= nx_pos[k];
            st_neg[k]   <= src_neg[k];
         end
         // The last stage doubles as the output register and holds across bubbles.
         if (src_v[NSEG-1]) begin
            st_found[NSEG-1] <= nx_found[NSEG-1];
            st_pos[NSEG-1]   <= nx_pos[NSEG-1];
            st_neg[NSEG-1]   <= src_neg[NSEG-1];
         end
         // Peak hold tracks presented results; a clear coinciding with a result restarts from it.
         if (out_valid) begin
            if (max_clear || out_pos > max_pos)
               max_pos <= out_pos;
         end else if (max_clear) begin
            max_pos <= FLOOR_POS;
         end
      end
   end

   assign out_valid = st_v[NSEG-1];
   assign out_pos   = st_pos[NSEG-1];
   assign out_found = st_found[NSEG-1];
   assign out_neg   = st_neg[NSEG-1];

endmodule

// File: tb/tb_fll_lead_detect_pipe.sv
// Bench for fll_lead_detect_pipe: default build plus a 24-bit, four-stage instance,
// both compared against a behavioural leading-one model.
module tb_fll_lead_detect_pipe;

   localparam int IW    = 18;
   localparam int MP    = 8;
   localparam int SW    = 5;
   localparam int OW    = 5;
   localparam int NSEG  = (IW - MP + SW - 1) / SW;
   localparam int FLOOR = MP - 1;

   localparam int WIW   = 24;
   localparam int WMP   = 4;
   localparam int WSW   = 6;
   localparam int WNSEG = (WIW - WMP + WSW - 1) / WSW;

   logic          clk;
   logic          d_reset, d_in_valid, d_max_clear;
   logic [IW-1:0] d_in;
   logic          d_out_valid, d_out_found, d_out_neg;
   logic [OW-1:0] d_out_pos, d_max_pos;

   logic           w_reset, w_in_valid, w_max_clear;
   logic [WIW-1:0] w_in;
   logic           w_out_valid, w_out_found, w_out_neg;
   logic [OW-1:0]  w_out_pos, w_max_pos;

   int checks = 0;
   int errors = 0;
   bit checks_on = 0;

   // result entries: {valid, neg, found, pos[4:0]}
   logic [7:0] exp_q[$];
   logic       e_valid, e_found, e_neg;
   int         e_pos, e_max;

   fll_lead_detect_pipe dut (
      .clk(clk), .reset(d_reset), .in_valid(d_in_valid), .in(d_in), .max_clear(d_max_clear),
      .out_valid(d_out_valid), .out_pos(d_out_pos), .out_found(d_out_found),
      .out_neg(d_out_neg), .max_pos(d_max_pos)
   );

   fll_lead_detect_pipe #(.IN_WIDTH(WIW), .MIN_POS(WMP), .SEG_WIDTH(WSW), .OUT_WIDTH(OW)) dut_wide (
      .clk(clk), .reset(w_reset), .in_valid(w_in_valid), .in(w_in), .max_clear(w_max_clear),
      .out_valid(w_out_valid), .out_pos(w_out_pos), .out_found(w_out_found),
      .out_neg(w_out_neg), .max_pos(w_max_pos)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Highest bit at or above mp that is set (or differs from the sign in signed mode).
   function automatic void ref_lod(input logic [31:0] w, input int iw, input int mp,
                                   output logic found, output int pos, output logic neg);
      int top;
      neg = 1'b0;
      top = iw - 1;
`ifdef FLL_PENC_SIGNED_EN
      neg = w[iw-1];
      top = iw - 2;
`endif
      found = 1'b0;
      pos   = mp - 1;
      for (int i = top; i >= mp; i--) begin
         if (!found && w[i] != neg) begin
            found = 1'b1;
            pos   = i;
         end
      end
   endfunction

   // Compare against the current model state, then apply inputs for the coming edge.
   task automatic step(input logic v, input logic [IW-1:0] w, input logic clr, input logic rst);
      logic       f, n;
      int         p;
      logic [7:0] front;
      @(negedge clk);
      if (checks_on) begin
         check("out_valid", 32'(d_out_valid), 32'(e_valid));
         check("out_pos",   32'(d_out_pos),   32'(e_pos));
         check("out_found", 32'(d_out_found), 32'(e_found));
         check("out_neg",   32'(d_out_neg),   32'(e_neg));
         check("max_pos",   32'(d_max_pos),   32'(e_max));
      end
      d_in_valid  = v;
      d_in        = w;
      d_max_clear = clr;
      d_reset     = rst;
      if (rst) begin
         e_valid = 1'b0; e_found = 1'b0; e_neg = 1'b0; e_pos = FLOOR; e_max = FLOOR;
         exp_q.delete();
         repeat (NSEG - 1) exp_q.push_back(8'h00);
      end else begin
         ref_lod(32'(w), IW, MP, f, p, n);
         exp_q.push_back({v, n, f, 5'(p)});
         front = exp_q.pop_front();
         if (e_valid) e_max = clr ? e_pos : (e_pos > e_max ? e_pos : e_max);
         else if (clr) e_max = FLOOR;
         e_valid = front[7];
         if (front[7]) begin
            e_neg = front[6]; e_found = front[5]; e_pos = int'(front[4:0]);
         end
      end
      checks_on = 1'b1;
   endtask

   task automatic wide_sample(input logic [WIW-1:0] w, inout int wmax);
      logic f, n;
      int   p, lat;
      ref_lod(32'(w), WIW, WMP, f, p, n);
      @(negedge clk);
      w_in_valid = 1'b1;
      w_in       = w;
      @(negedge clk);
      w_in_valid = 1'b0;
      lat = 1;
      while (!w_out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check("w_latency", 32'(lat), 32'(WNSEG));
      check("w_out_pos", 32'(w_out_pos), 32'(p));
      check("w_out_found", 32'(w_out_found), 32'(f));
      check("w_out_neg", 32'(w_out_neg), 32'(n));
      if (p > wmax) wmax = p;
      @(negedge clk);
      check("w_out_valid_drop", 32'(w_out_valid), 32'(0));
      check("w_max_pos", 32'(w_max_pos), 32'(wmax));
   endtask

   initial begin
      int wmax;
      logic [IW-1:0] rw;
      d_reset = 1'b1; d_in_valid = 1'b0; d_in = '0; d_max_clear = 1'b0;
      w_reset = 1'b1; w_in_valid = 1'b0; w_in = '0; w_max_clear = 1'b0;

      step(0, '0, 0, 1);
      step(0, '0, 0, 1);
      step(0, '0, 0, 0);

      // directed positions: 17, 8, none, 12
      step(1, 18'h20000, 0, 0);
      step(1, 18'h00100, 0, 0);
      step(1, 18'h000FF, 0, 0);
      step(1, 18'h01000, 0, 0);
      // stream with a bubble
      step(1, 18'h00400, 0, 0);
      step(0, 18'h3FFFF, 0, 0);
      step(1, 18'h08000, 0, 0);
      step(1, 18'h00200, 0, 0);
      step(0, '0, 0, 0);
      step(0, '0, 0, 0);
      step(0, '0, 1, 0);
      // peak hold 10, 14, 9, then clear alongside a result, then clear alone
      step(1, 18'h00400, 0, 0);
      step(1, 18'h04000, 0, 0);
      step(1, 18'h00200, 0, 0);
      step(1, 18'h00200, 0, 0);
      step(0, '0, 0, 0);
      step(0, '0, 1, 0);
      step(0, '0, 0, 0);
      step(0, '0, 1, 0);
      step(0, '0, 0, 0);
      // reset while a sample is in flight
      step(1, 18'h20000, 0, 0);
      step(0, '0, 1, 1);
      step(0, '0, 0, 0);
      step(0, '0, 0, 0);
      // sign-mode pattern
      step(1, 18'h3FEFF, 0, 0);
      step(0, '0, 0, 0);
      step(0, '0, 0, 0);

      for (int n = 0; n < 400; n++) begin
         rw = IW'($urandom >> $urandom_range(0, 31));
         step($urandom_range(0, 3) != 0, rw, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
      end
      repeat (NSEG + 2) step(0, '0, 0, 0);

      // wide instance
      @(negedge clk);
      w_reset = 1'b0;
      @(negedge clk);
      check("w_reset_pos", 32'(w_out_pos), 32'(WMP - 1));
      check("w_reset_max", 32'(w_max_pos), 32'(WMP - 1));
      check("w_reset_valid", 32'(w_out_valid), 32'(0));
      wmax = WMP - 1;
      wide_sample(24'h000010, wmax);
      for (int n = 0; n < 20; n++)
         wide_sample(WIW'($urandom >> $urandom_range(0, 31)), wmax);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fll_lead_detect_pipe.md
Name: fll_lead_detect_pipe

Overview:
Parametrised, fully pipelined leading-one detector for the FLL discriminator path. It finds the most-significant set bit of an input word within a configurable search window, one segment per pipeline stage, and reports its position with valid tagging. A running peak-position tracker over a software-cleared window feeds FLL gain normalisation. With default parameters it is cycle- and value-compatible with the current fixed 18-bit, two-stage FLL encoder.

Parameters:
IN_WIDTH, 18, input word width.
MIN_POS, 8, lowest bit position searched; bits below are ignored.
SEG_WIDTH, 5, bits examined per pipeline stage.
OUT_WIDTH, 5, width of position outputs; must hold IN_WIDTH-1.
Derived: NSEG = ceil((IN_WIDTH-MIN_POS)/SEG_WIDTH), the pipeline depth. FLOOR_POS = MIN_POS-1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input sample strobe
in  in  IN_WIDTH  input word
max_clear  in  1  restart peak-hold window
out_valid  out  1  result strobe, NSEG cycles after in_valid
out_pos  out  OUT_WIDTH  leading-one position, or FLOOR_POS if none
out_found  out  1  1 if a set bit was found in the window
out_neg  out  1  input sign in signed mode; 0 otherwise
max_pos  out  OUT_WIDTH  largest out_pos since last clear/reset

Behaviour:
- Reset (synchronous, active-high, `reset`):
  - out_valid=0, out_pos=FLOOR_POS, out_found=0, out_neg=0, max_pos=FLOOR_POS.
  - All stage valid bits are cleared. In-flight samples are discarded and never emerge.
- Segmentation:
  - Segment 0 = in[IN_WIDTH-1 : IN_WIDTH-SEG_WIDTH], segment k is the next SEG_WIDTH bits down.
  - The last segment is truncated at MIN_POS (a partial segment is allowed).
- Stage k (registered):
  - Carries valid, found, pos, and the unexamined lower bits of the word.
  - If found is already set, found and pos pass through unchanged.
  - Otherwise it searches segment k from MSB down. The first 1 at bit i sets found=1, pos=i.
- Latency: exactly NSEG cycles from in_valid to out_valid. Throughput is one sample per cycle, with no backpressure.
  - Bubbles (in_valid=0) propagate as out_valid=0.
  - Sample order is preserved.
- Outputs:
  - out_pos, out_found and out_neg update only on cycles where out_valid=1; otherwise they hold their last values.
  - If no bit is set in [IN_WIDTH-1:MIN_POS]: out_pos=FLOOR_POS, out_found=0.
- Peak hold:
  - On out_valid: max_pos <= max(max_pos, out_pos_new) (unsigned compare).
  - max_clear alone: max_pos <= FLOOR_POS on the next cycle.
  - max_clear together with out_valid in the same cycle: max_pos <= out_pos_new, so the new window starts with that sample.
  - reset takes priority over max_clear.
- Parameter legality:
  - MIN_POS >= 1.
  - IN_WIDTH > MIN_POS.
  - 2^OUT_WIDTH > IN_WIDTH-1.
  - Violations stop elaboration via a generate-time error.

Optional Feature:
Macro FLL_PENC_SIGNED_EN.
- Defined:
  - The input is two's complement. The sign bit in[IN_WIDTH-1] is excluded from the search.
  - The detector finds the highest bit i in [IN_WIDTH-2:MIN_POS] where in[i] != sign, implemented as an XOR with the sign before segmentation.
  - The sign is pipelined alongside the data and output on out_neg, aligned with out_valid.
  - The no-bit-found case gives out_pos=FLOOR_POS, as in unsigned mode.
- Undefined: unsigned behaviour as above, and out_neg is tied 0.

Test Plan (default parameters unless stated):
- in=18'h20000, in_valid pulse at cycle 0 -> cycle 2: out_valid=1, out_pos=17, out_found=1. Next sample in=18'h00100 -> out_pos=8, out_found=1.
- in=18'h000FF -> out_pos=7, out_found=0. in=18'h01000 -> out_pos=12 (resolved in stage 1).
- Stream 18'h00400, bubble, 18'h08000, 18'h00200 on consecutive cycles -> out_valid pattern 1,0,1,1 with out_pos 10, 15, 9. Outputs hold through the bubble.
- Peak hold: samples with positions 10, 14, 9 -> max_pos 10, 14, 14. Then max_clear together with a sample at position 9 -> max_pos=9. Then max_clear alone -> 7.
- Reset mid-flight: in_valid at cycle 0, reset at cycle 1 -> no out_valid at cycle 2, and all outputs equal their reset values.
- FLL_PENC_SIGNED_EN defined, in=18'h3FEFF -> out_pos=8, out_neg=1, out_found=1. Same stimulus with the macro undefined -> out_pos=17, out_neg=0. Also run with IN_WIDTH=24, MIN_POS=4, SEG_WIDTH=6 (NSEG=4): in=24'h000010 -> out_pos=4 after 4 cycles.
